// File: rtl/cam_gen_pkg.sv
// Shared types and constants for the camera stream emulator: FSM states,
// RGB565 colour-bar palette, pattern codes and the per-frame config record.
package cam_gen_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_VSYNC  = 3'd1,
    ST_VBACK  = 3'd2,
    ST_ACTIVE = 3'd3,
    ST_VFRONT = 3'd4
  } cam_state_e;

  localparam logic PAT_BARS = 1'b0;
  localparam logic PAT_BALL = 1'b1;

  localparam logic [15:0] COL_WHITE   = 16'hFFFF;
  localparam logic [15:0] COL_YELLOW  = 16'hFFE0;
  localparam logic [15:0] COL_CYAN    = 16'h07FF;
  localparam logic [15:0] COL_GREEN   = 16'h07E0;
  localparam logic [15:0] COL_MAGENTA = 16'hF81F;
  localparam logic [15:0] COL_RED     = 16'hF800;
  localparam logic [15:0] COL_BLUE    = 16'h001F;
  localparam logic [15:0] COL_BLACK   = 16'h0000;

  typedef struct packed {
    logic        pattern;
    logic [9:0]  ball_x;
    logic [9:0]  ball_y;
    logic [7:0]  ball_r;
    logic [15:0] fg_color;
    logic [15:0] bg_color;
  } cam_cfg_t;

  function automatic logic [15:0] bar_color(input logic [2:0] idx);
    logic [15:0] c;
    case (idx)
      3'd0:    c = COL_WHITE;
      3'd1:    c = COL_YELLOW;
      3'd2:    c = COL_CYAN;
      3'd3:    c = COL_GREEN;
      3'd4:    c = COL_MAGENTA;
      3'd5:    c = COL_RED;
      3'd6:    c = COL_BLUE;
      default: c = COL_BLACK;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/cam_pixel_src.sv
// Pure combinational pixel generator: (x, y, frame config) -> RGB565 word.
// Colour bars or a clipped square ball on a background.
module cam_pixel_src
  import cam_gen_pkg::*;
#(
  parameter int H_ACTIVE = 640
) (
  input  logic [9:0]  x,
  input  logic [9:0]  y,
  input  cam_cfg_t    cfg,
  output logic [15:0] pixel
);

  localparam logic [9:0] BAR_W = 10'(H_ACTIVE / 8);

  logic [2:0]         bar_idx;
  logic signed [10:0] dx;
  logic signed [10:0] dy;
  logic [10:0]        adx;
  logic [10:0]        ady;
  logic               in_ball;

  assign bar_idx = 3'(x / BAR_W);

  // Signed differences keep the ball from wrapping around the frame edges.
  assign dx  = $signed({1'b0, x}) - $signed({1'b0, cfg.ball_x});
  assign dy  = $signed({1'b0, y}) - $signed({1'b0, cfg.ball_y});
  assign adx = dx[10] ? $unsigned(-dx) : $unsigned(dx);
  assign ady = dy[10] ? $unsigned(-dy) : $unsigned(dy);
  assign in_ball = (adx < {3'b000, cfg.ball_r}) && (ady < {3'b000, cfg.ball_r});

  always_comb begin
    pixel = bar_color(bar_idx);
    if (cfg.pattern == PAT_BALL) begin
      pixel = in_ball ? cfg.fg_color : cfg.bg_color;
    end
  end

endmodule

// File: rtl/cam_stream_gen.sv
// Camera-side frame emulator driving apclk/ahref/avsync/adata with RGB565 pixels.
// Optional per-frame checksum on frame_sum when CAMGEN_CHECKSUM_EN is defined.
module cam_stream_gen
  import cam_gen_pkg::*;
#(
  parameter int H_ACTIVE      = 640,
  parameter int V_ACTIVE      = 480,
  parameter int H_BLANK       = 288,
  parameter int V_SYNC_LINES  = 3,
  parameter int V_BACK_LINES  = 17,
  parameter int V_FRONT_LINES = 10,
  parameter int PCLK_HALF     = 2
) (
  input  logic        clk,
  input  logic        res_n,
  input  logic        enable,
  input  logic        pattern,
  input  logic [9:0]  ball_x,
  input  logic [9:0]  ball_y,
  input  logic [7:0]  ball_r,
  input  logic [15:0] fg_color,
  input  logic [15:0] bg_color,
  output logic        apclk,
  output logic        ahref,
  output logic        avsync,
  output logic [7:0]  adata,
  output logic        frame_start,
  output logic        busy,
  output logic [15:0] frame_sum
);

  localparam logic [15:0] L_LAST   = 16'(2 * H_ACTIVE + H_BLANK - 1);
  localparam logic [15:0] H_BYTES  = 16'(2 * H_ACTIVE);
  localparam logic [15:0] DIV_LAST = 16'(PCLK_HALF - 1);

  cam_state_e  state_q, state_d;
  logic [15:0] hcnt_q, hcnt_d;
  logic [15:0] vcnt_q, vcnt_d;
  logic [15:0] div_q, div_d;
  logic        apclk_q, apclk_d;
  logic        avsync_q, avsync_d;
  logic        ahref_q, ahref_d;
  logic [7:0]  adata_q, adata_d;
  logic        frame_start_q, frame_start_d;
  logic        busy_q, busy_d;
  cam_cfg_t    cfg_q, cfg_d;
  logic        fall_tick;
  logic        start_frame;
  logic [15:0] pixel;

  function automatic logic [15:0] phase_last(input cam_state_e s);
    logic [15:0] n;
    case (s)
      ST_VSYNC:  n = 16'(V_SYNC_LINES - 1);
      ST_VBACK:  n = 16'(V_BACK_LINES - 1);
      ST_ACTIVE: n = 16'(V_ACTIVE - 1);
      ST_VFRONT: n = 16'(V_FRONT_LINES - 1);
      default:   n = 16'h0000;
    endcase
    return n;
  endfunction

  // Zero-line phases are skipped by falling through to the following phase.
  function automatic cam_state_e next_phase(input cam_state_e s, input logic en);
    cam_state_e after_front, from_active, from_back, from_sync, n;
    after_front = en ? ST_VSYNC : ST_IDLE;
    from_active = (V_FRONT_LINES > 0) ? ST_VFRONT : after_front;
    from_back   = (V_ACTIVE > 0) ? ST_ACTIVE : from_active;
    from_sync   = (V_BACK_LINES > 0) ? ST_VBACK : from_back;
    case (s)
      ST_VSYNC:  n = from_sync;
      ST_VBACK:  n = from_back;
      ST_ACTIVE: n = from_active;
      ST_VFRONT: n = after_front;
      default:   n = ST_IDLE;
    endcase
    return n;
  endfunction

  always_comb begin
    state_d     = state_q;
    hcnt_d      = hcnt_q;
    vcnt_d      = vcnt_q;
    div_d       = div_q;
    apclk_d     = apclk_q;
    fall_tick   = 1'b0;
    start_frame = 1'b0;
    if (state_q == ST_IDLE) begin
      apclk_d     = 1'b0;
      div_d       = 16'h0000;
      start_frame = enable;
    end else begin
      if (div_q == DIV_LAST) begin
        div_d     = 16'h0000;
        apclk_d   = ~apclk_q;
        fall_tick = apclk_q;
      end else begin
        div_d = div_q + 16'h0001;
      end
      if (fall_tick) begin
        if (hcnt_q == L_LAST) begin
          hcnt_d = 16'h0000;
          if (vcnt_q == phase_last(state_q)) begin
            vcnt_d      = 16'h0000;
            state_d     = next_phase(state_q, enable);
            start_frame = (state_d == ST_VSYNC);
          end else begin
            vcnt_d = vcnt_q + 16'h0001;
          end
        end else begin
          hcnt_d = hcnt_q + 16'h0001;
        end
      end
    end
    if (start_frame) begin
      state_d = ST_VSYNC;
      hcnt_d  = 16'h0000;
      vcnt_d  = 16'h0000;
    end
  end

  always_comb begin
    cfg_d = cfg_q;
    if (start_frame) begin
      cfg_d.pattern  = pattern;
      cfg_d.ball_x   = ball_x;
      cfg_d.ball_y   = ball_y;
      cfg_d.ball_r   = ball_r;
      cfg_d.fg_color = fg_color;
      cfg_d.bg_color = bg_color;
    end
  end

  cam_pixel_src #(
    .H_ACTIVE (H_ACTIVE)
  ) u_pixel_src (
    .x     (hcnt_d[10:1]),
    .y     (vcnt_d[9:0]),
    .cfg   (cfg_q),
    .pixel (pixel)
  );

  // Bus outputs describe the upcoming pclk period, so they only move on the apclk fall.
  always_comb begin
    avsync_d      = avsync_q;
    ahref_d       = ahref_q;
    adata_d       = adata_q;
    frame_start_d = start_frame;
    busy_d        = (state_d != ST_IDLE);
    if (fall_tick || start_frame) begin
      avsync_d = (state_d == ST_VSYNC);
      ahref_d  = (state_d == ST_ACTIVE) && (hcnt_d < H_BYTES);
      adata_d  = 8'h00;
      if (ahref_d) begin
        adata_d = hcnt_d[0] ? pixel[7:0] : pixel[15:8];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!res_n) begin
      state_q       <= ST_IDLE;
      hcnt_q        <= 16'h0000;
      vcnt_q        <= 16'h0000;
      div_q         <= 16'h0000;
      apclk_q       <= 1'b0;
      avsync_q      <= 1'b0;
      ahref_q       <= 1'b0;
      adata_q       <= 8'h00;
      frame_start_q <= 1'b0;
      busy_q        <= 1'b0;
      cfg_q         <= '0;
    end else begin
      state_q       <= state_d;
      hcnt_q        <= hcnt_d;
      vcnt_q        <= vcnt_d;
      div_q         <= div_d;
      apclk_q       <= apclk_d;
      avsync_q      <= avsync_d;
      ahref_q       <= ahref_d;
      adata_q       <= adata_d;
      frame_start_q <= frame_start_d;
      busy_q        <= busy_d;
      cfg_q         <= cfg_d;
    end
  end

  assign apclk       = apclk_q;
  assign ahref       = ahref_q;
  assign avsync      = avsync_q;
  assign adata       = adata_q;
  assign frame_start = frame_start_q;
  assign busy        = busy_q;

`ifdef CAMGEN_CHECKSUM_EN
  logic [15:0] sum_q, sum_d;
  logic [15:0] frame_sum_q, frame_sum_d;

  // Each pixel word is added once, when its high byte goes out.
  always_comb begin
    sum_d       = sum_q;
    frame_sum_d = frame_sum_q;
    if (start_frame) begin
      sum_d = 16'h0000;
    end else if (fall_tick && ahref_d && !hcnt_d[0]) begin
      sum_d = sum_q + pixel;
    end
    if (fall_tick && (state_q == ST_ACTIVE) && (state_d != ST_ACTIVE)) begin
      frame_sum_d = sum_q;
    end
  end

  always_ff @(posedge clk) begin
    if (!res_n) begin
      sum_q       <= 16'h0000;
      frame_sum_q <= 16'h0000;
    end else begin
      sum_q       <= sum_d;
      frame_sum_q <= frame_sum_d;
    end
  end

  assign frame_sum = frame_sum_q;
`else
  assign frame_sum = 16'h0000;
`endif

endmodule

// File: doc/cam_stream_gen.md
Name: cam_stream_gen

Overview:
Camera-side emulator: the transmitting end of the pixel capture interface (apclk/ahref/avsync/adata). It generates parallel-camera-style frames of RGB565 pixels, two bytes per pixel with the high byte first. It drives vline_capture/pixcopy/rgb2hsv in place of the physical sensor for bring-up and regression. Frames carry either colour bars or a square "ball" on a background, so detector output can be checked against known geometry.

Parameters:
H_ACTIVE, 640, active pixels per line (must be a multiple of 8)
V_ACTIVE, 480, active lines per frame
H_BLANK, 288, pclk periods per line with ahref low
V_SYNC_LINES, 3, lines with avsync high
V_BACK_LINES, 17, lines between avsync fall and the first active line
V_FRONT_LINES, 10, lines after the last active line, before the next avsync
PCLK_HALF, 2, clk cycles per apclk half-period (must be >= 1)

Ports:
clk  in  1  system clock
res_n  in  1  synchronous reset, active-low
enable  in  1  run frames; sampled at frame boundaries
pattern  in  1  0 = colour bars, 1 = ball
ball_x  in  10  ball centre column
ball_y  in  10  ball centre row
ball_r  in  8  ball half-size, in pixels
fg_color  in  16  ball RGB565 colour
bg_color  in  16  background RGB565 colour
apclk  out  1  emulated pixel clock
ahref  out  1  line-valid strobe
avsync  out  1  frame sync, active high
adata  out  8  byte bus
frame_start  out  1  one-clk pulse when avsync rises
busy  out  1  high from frame start until the frame ends
frame_sum  out  16  per-frame checksum (optional feature)

Behaviour:
- Reset: on a clk edge with res_n=0, every output goes to 0, the FSM goes to IDLE, and all counters clear. A reset mid-frame aborts the frame immediately, with no trailing ahref.
- apclk: toggles every PCLK_HALF clk cycles while the FSM is not IDLE, and is held at 0 in IDLE. All of avsync, ahref and adata change only in the clk cycle in which apclk falls. This gives sinks that sample on apclk high PCLK_HALF cycles of setup.
- Line length: L = 2*H_ACTIVE + H_BLANK pclk periods. Counters hcnt (0..L-1) and vcnt (line index within the current phase) advance per pclk period.
- FSM states:
  - IDLE: if enable=1, go to VSYNC. This asserts avsync and frame_start, and latches pattern, ball_x, ball_y, ball_r, fg_color and bg_color for the whole frame.
  - VSYNC: lasts V_SYNC_LINES lines, then avsync falls and the FSM goes to VBACK.
  - VBACK: lasts V_BACK_LINES lines, then goes to ACTIVE.
  - ACTIVE: lasts V_ACTIVE lines. In each line, ahref is high for hcnt 0..2*H_ACTIVE-1 and low for the H_BLANK remainder. Byte k of the line belongs to pixel x = k>>1 on row y = current active line; even k carries pixel[15:8], odd k carries pixel[7:0]. adata = 0 while ahref = 0.
  - VFRONT: lasts V_FRONT_LINES lines. Then, if the latched-at-boundary enable = 1, go to VSYNC (new frame); otherwise go to IDLE.
- enable deasserted mid-frame: the current frame completes, then the FSM goes to IDLE.
- busy: 1 in every state except IDLE.
- Pixel generation:
  - Colour bars: bar = x / (H_ACTIVE/8). The colours are, in order: white, yellow, cyan, green, magenta, red, blue, black (constants in the package).
  - Ball: pixel = fg_color when |x-ball_x| < ball_r and |y-ball_y| < ball_r, else bg_color. Use 11-bit signed differences.
  - ball_r = 0 produces no ball. A ball that crosses an edge is clipped with no wrap-around.
- Zero-length phases: a phase parameter of 0 skips that state (a transition through it takes 0 lines). V_SYNC_LINES must be >= 1.

Optional Feature:
CAMGEN_CHECKSUM_EN
- With the macro defined: a 16-bit wrap-around sum of every transmitted pixel word accumulates over ACTIVE. It is copied to frame_sum on entry to VFRONT, and the accumulator clears at frame_start.
- Without the macro: frame_sum is tied to 0 and no accumulator logic exists.

Decomposition:
- Package cam_gen_pkg: FSM state enum (IDLE, VSYNC, VBACK, ACTIVE, VFRONT), the 8 RGB565 bar-colour constants, and pattern codes PAT_BARS/PAT_BALL.
- Sub-module cam_pixel_src: pure combinational (x, y, latched config) -> 16-bit pixel, so it can be reused by a software model checker.
- The top contains the pclk divider, the counters and the FSM.

Test Plan:
All cases use H_ACTIVE=8, V_ACTIVE=4, H_BLANK=4, V_SYNC_LINES=1, V_BACK_LINES=1, V_FRONT_LINES=1, PCLK_HALF=1 unless stated.
1. Reset, then enable=1, pattern=0 -> frame_start pulses once; avsync high for 20 pclks; each active line has exactly 16 ahref-high pclks; bytes are FF FF, FF E0, 07 FF, 07 E0, F8 1F, F8 00, 00 1F, 00 00.
2. pattern=1, ball_x=3, ball_y=2, ball_r=1, fg=F800, bg=001F -> only pixel (3,2) is F800 (bytes F8 00 at k=6,7 of active line 2); all other pixels are 001F.
3. pattern=1, ball_x=0, ball_y=0, ball_r=2 -> pixels (0..1, 0..1) are fg and all others are bg; no fg appears at x=6..7 (no wrap).
4. Drop enable in the middle of active line 1 -> the frame completes all 4 active lines and VFRONT, then apclk is held at 0, busy=0, and no second frame_start occurs.
5. Assert res_n=0 during byte 5 of active line 2 -> on the next clk every output is 0; after res_n=1 with enable=1, a fresh frame starts at VSYNC.
6. With CAMGEN_CHECKSUM_EN defined, pattern=1, ball_r=0, bg=0x1234 -> frame_sum = 32*0x1234 mod 2^16 = 0x4680; without the macro, frame_sum = 0.
